// File: rtl/predicate_mask_reader_if.sv
// Request/response handshake bundle between the issue stage and predicate_mask_reader.
// Latency: none (wires only).
// Backpressure: req_ready / resp_ready carry stalls in each direction.
// Ports: req_* = warp/register/op/lane request with valid-ready;
//        resp_* = combined lane mask plus any/all flags with valid-ready.
interface predicate_mask_reader_if #(
    parameter int NUM_LANES = 16,
    parameter int WARP_W    = 3,
    parameter int PADDR_W   = 5
);
    logic                 req_valid;
    logic                 req_ready;
    logic [WARP_W-1:0]    req_warp;
    logic [PADDR_W-1:0]   req_paddr_a;
    logic [PADDR_W-1:0]   req_paddr_b;
    logic [1:0]           req_op;
    logic [NUM_LANES-1:0] req_lane_en;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [NUM_LANES-1:0] resp_mask;
    logic                 resp_any;
    logic                 resp_all;

    // Issue-stage side
    modport master (
        output req_valid, req_warp, req_paddr_a, req_paddr_b, req_op, req_lane_en, resp_ready,
        input  req_ready, resp_valid, resp_mask, resp_any, resp_all
    );

    // Reader side
    modport slave (
        input  req_valid, req_warp, req_paddr_a, req_paddr_b, req_op, req_lane_en, resp_ready,
        output req_ready, resp_valid, resp_mask, resp_any, resp_all
    );
endinterface

// File: rtl/predicate_mask_reader.sv
// Read-side controller for the predicate register block: reads one or two predicate
// registers of a warp, combines them under a lane mask, returns mask + any/all.
// Latency: accept -> resp_valid in 2+RD_LATENCY cycles (plus hazard stall cycles).
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
// Ports: clk/rst (sync, active-high); bus = request/response handshake (slave);
//        warp_selector/read_en_*/raddr_* drive the register block, rdata_* return from it;
//        snoop_wen/snoop_waddr observe its write port; busy = not IDLE.
module predicate_mask_reader #(
    parameter int NUM_LANES  = 16,
    parameter int WARP_W     = 3,
    parameter int PADDR_W    = 5,
    parameter int RD_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    predicate_mask_reader_if.slave bus,
    output logic [WARP_W-1:0]     warp_selector,
    output logic [NUM_LANES-1:0]  read_en_0,
    output logic [NUM_LANES-1:0]  read_en_1,
    output logic [PADDR_W-1:0]    raddr_0,
    output logic [PADDR_W-1:0]    raddr_1,
    input  logic [NUM_LANES-1:0]  rdata_0,
    input  logic [NUM_LANES-1:0]  rdata_1,
    input  logic [NUM_LANES-1:0]  snoop_wen,
    input  logic [PADDR_W-1:0]    snoop_waddr,
    output logic                  busy
);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int LOADV = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WARP_W-1:0]    warp_q, warp_d;
    logic [PADDR_W-1:0]   pa_q, pa_d;
    logic [PADDR_W-1:0]   pb_q, pb_d;
    logic [1:0]           op_q, op_d;
    logic [NUM_LANES-1:0] lane_q, lane_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic                 any_q, any_d;
    logic                 all_q, all_d;

    logic                 reading;
    logic                 hazard;
    logic [NUM_LANES-1:0] comb_mask;

    // Read ports are live for the whole ISSUE/WAIT window.
    assign reading = (state_q == ISSUE) || (state_q == WAIT);

    // Port B only matters when the op actually uses it; lanes we do not read cannot go stale.
    assign hazard = (|(snoop_wen & lane_q)) &&
                    ((snoop_waddr == pa_q) || ((op_q != 2'b00) && (snoop_waddr == pb_q)));

    always_comb begin
        comb_mask = rdata_0;
        case (op_q)
            2'b00:   comb_mask = rdata_0;
            2'b01:   comb_mask = rdata_0 & rdata_1;
            2'b10:   comb_mask = rdata_0 | rdata_1;
            default: comb_mask = rdata_0 & ~rdata_1;
        endcase
        comb_mask = comb_mask & lane_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        warp_d  = warp_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        op_d    = op_q;
        lane_d  = lane_q;
        mask_d  = mask_q;
        any_d   = any_q;
        all_d   = all_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    warp_d  = bus.req_warp;
                    pa_d    = bus.req_paddr_a;
                    pb_d    = bus.req_paddr_b;
                    op_d    = bus.req_op;
                    lane_d  = bus.req_lane_en;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!hazard) begin
                    if (RD_LATENCY == 0) begin
                        mask_d  = comb_mask;
                        any_d   = |comb_mask;
                        all_d   = (comb_mask == lane_q);
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(LOADV);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    mask_d  = comb_mask;
                    any_d   = |comb_mask;
                    all_d   = (comb_mask == lane_q);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (bus.resp_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            warp_q  <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            op_q    <= '0;
            lane_q  <= '0;
            mask_q  <= '0;
            any_q   <= 1'b0;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            warp_q  <= warp_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            mask_q  <= mask_d;
            any_q   <= any_d;
            all_q   <= all_d;
        end
    end

    // Addresses and warp come straight from the latched request, so they hold through RESP.
    assign warp_selector  = warp_q;
    assign raddr_0        = pa_q;
    assign raddr_1        = pb_q;
    assign read_en_0      = reading ? lane_q : '0;
    assign read_en_1      = (reading && (op_q != 2'b00)) ? lane_q : '0;
    assign busy           = (state_q != IDLE);
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_mask  = mask_q;
    assign bus.resp_any   = any_q;
    assign bus.resp_all   = all_q;
endmodule

// File: tb/tb_predicate_mask_reader.sv
// Directed bench for predicate_mask_reader with a behavioural predicate register file.
// Latency: two DUT copies, RD_LATENCY=0 (u0) and RD_LATENCY=2 (u2).
// Backpressure: resp_ready driven directly; stall windows exercised explicitly.
module tb_predicate_mask_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Predicate register file model: mem[warp][reg], one bit per lane.
    logic [15:0] mem [0:7][0:31];

    logic [15:0] snoop_wen;
    logic [4:0]  snoop_waddr;

    predicate_mask_reader_if #(.NUM_LANES(16), .WARP_W(3), .PADDR_W(5)) if0 ();
    predicate_mask_reader_if #(.NUM_LANES(16), .WARP_W(3), .PADDR_W(5)) if2 ();

    logic [2:0]  ws0, ws2;
    logic [15:0] ren00, ren01, ren20, ren21;
    logic [4:0]  ra00, ra01, ra20, ra21;
    logic [15:0] rd00, rd01, rd20, rd21;
    logic        busy0, busy2;

    assign rd00 = mem[ws0][ra00] & ren00;
    assign rd01 = mem[ws0][ra01] & ren01;
    assign rd20 = mem[ws2][ra20] & ren20;
    assign rd21 = mem[ws2][ra21] & ren21;

    predicate_mask_reader #(.NUM_LANES(16), .WARP_W(3), .PADDR_W(5), .RD_LATENCY(0)) u0 (
        .clk(clk), .rst(rst), .bus(if0),
        .warp_selector(ws0), .read_en_0(ren00), .read_en_1(ren01),
        .raddr_0(ra00), .raddr_1(ra01), .rdata_0(rd00), .rdata_1(rd01),
        .snoop_wen(snoop_wen), .snoop_waddr(snoop_waddr), .busy(busy0)
    );

    predicate_mask_reader #(.NUM_LANES(16), .WARP_W(3), .PADDR_W(5), .RD_LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .bus(if2),
        .warp_selector(ws2), .read_en_0(ren20), .read_en_1(ren21),
        .raddr_0(ra20), .raddr_1(ra21), .rdata_0(rd20), .rdata_1(rd21),
        .snoop_wen(16'h0000), .snoop_waddr(5'd0), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply the register-block write that the DUT saw at the last edge (warp = u0 selector).
    task automatic model_write(input logic [15:0] wdata);
        mem[ws0][snoop_waddr] = (mem[ws0][snoop_waddr] & ~snoop_wen) | (wdata & snoop_wen);
    endtask

    // One full request on u0 with resp_ready high; called at posedge+1.
    task automatic run_req(input string tag, input logic [2:0] w, input logic [4:0] a,
                           input logic [4:0] b, input logic [1:0] op, input logic [15:0] lane,
                           input logic [15:0] em, input logic ea, input logic eal);
        logic [15:0] eren1;
        eren1 = (op == 2'b00) ? 16'h0000 : lane;
        if0.req_warp    = w;
        if0.req_paddr_a = a;
        if0.req_paddr_b = b;
        if0.req_op      = op;
        if0.req_lane_en = lane;
        if0.req_valid   = 1'b1;
        chk({tag, ".req_ready"}, 32'(if0.req_ready), 32'd1);
        @(posedge clk); #1;
        if0.req_valid = 1'b0;
        chk({tag, ".iss_ren0"}, 32'(ren00), 32'(lane));
        chk({tag, ".iss_ren1"}, 32'(ren01), 32'(eren1));
        chk({tag, ".iss_warp"}, 32'(ws0), 32'(w));
        chk({tag, ".iss_raddr0"}, 32'(ra00), 32'(a));
        if (op != 2'b00) chk({tag, ".iss_raddr1"}, 32'(ra01), 32'(b));
        chk({tag, ".iss_busy"}, 32'(busy0), 32'd1);
        chk({tag, ".iss_rvld"}, 32'(if0.resp_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".resp_valid"}, 32'(if0.resp_valid), 32'd1);
        chk({tag, ".resp_mask"}, 32'(if0.resp_mask), 32'(em));
        chk({tag, ".resp_any"}, 32'(if0.resp_any), 32'(ea));
        chk({tag, ".resp_all"}, 32'(if0.resp_all), 32'(eal));
        chk({tag, ".resp_ren0"}, 32'(ren00), 32'd0);
        chk({tag, ".resp_ren1"}, 32'(ren01), 32'd0);
        chk({tag, ".resp_rdy"}, 32'(if0.req_ready), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".idle_busy"}, 32'(busy0), 32'd0);
        chk({tag, ".idle_rvld"}, 32'(if0.resp_valid), 32'd0);
    endtask

    initial begin
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 32; r++)
                mem[w][r] = 16'h0000;
        rst = 1'b1;
        snoop_wen = '0; snoop_waddr = '0;
        if0.req_valid = 0; if0.req_warp = 0; if0.req_paddr_a = 0; if0.req_paddr_b = 0;
        if0.req_op = 0; if0.req_lane_en = 0; if0.resp_ready = 1;
        if2.req_valid = 0; if2.req_warp = 0; if2.req_paddr_a = 0; if2.req_paddr_b = 0;
        if2.req_op = 0; if2.req_lane_en = 0; if2.resp_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst.req_ready", 32'(if0.req_ready), 32'd1);
        chk("rst.busy", 32'(busy0), 32'd0);
        chk("rst.resp_valid", 32'(if0.resp_valid), 32'd0);
        chk("rst.resp_mask", 32'(if0.resp_mask), 32'd0);
        chk("rst.ren", 32'({ren00, ren01}), 32'd0);
        chk("rst.addr", 32'({ws0, ra00, ra01}), 32'd0);

        // 1: single-register pass-through
        mem[0][3] = 16'hFFFF;
        run_req("t1", 3'd0, 5'd3, 5'd0, 2'b00, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);

        // 2: two-port ops
        mem[5][1] = 16'h00FF;
        mem[5][2] = 16'h0F0F;
        run_req("t2and",  3'd5, 5'd1, 5'd2, 2'b01, 16'hFFFF, 16'h000F, 1'b1, 1'b0);
        run_req("t2or",   3'd5, 5'd1, 5'd2, 2'b10, 16'hFFFF, 16'h0FFF, 1'b1, 1'b0);
        run_req("t2andn", 3'd5, 5'd1, 5'd2, 2'b11, 16'hFFFF, 16'h00F0, 1'b1, 1'b0);
        run_req("t2same", 3'd5, 5'd1, 5'd1, 2'b11, 16'hFFFF, 16'h0000, 1'b0, 1'b0);

        // 3: lane masking
        mem[2][7] = 16'hFFFF;
        mem[2][8] = 16'h1234;
        run_req("t3edge", 3'd2, 5'd7, 5'd0, 2'b00, 16'h8001, 16'h8001, 1'b1, 1'b1);
        run_req("t3none", 3'd2, 5'd7, 5'd0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1);
        run_req("t3part", 3'd2, 5'd8, 5'd0, 2'b00, 16'hFF00, 16'h1200, 1'b1, 1'b0);

        // 4: write hazard on port A stalls two cycles and returns the new data
        mem[3][4] = 16'h0000;
        if0.req_warp = 3'd3; if0.req_paddr_a = 5'd4; if0.req_paddr_b = 5'd9;
        if0.req_op = 2'b00; if0.req_lane_en = 16'hFFFF; if0.req_valid = 1'b1;
        @(posedge clk); #1;
        if0.req_valid = 1'b0;
        snoop_wen = 16'hFFFF; snoop_waddr = 5'd4;
        @(posedge clk); #1;
        model_write(16'hA5A5);
        chk("t4.stall1_rvld", 32'(if0.resp_valid), 32'd0);
        chk("t4.stall1_ren0", 32'(ren00), 32'hFFFF);
        @(posedge clk); #1;
        model_write(16'hC3C3);
        snoop_wen = 16'h0000;
        chk("t4.stall2_rvld", 32'(if0.resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("t4.resp_valid", 32'(if0.resp_valid), 32'd1);
        chk("t4.resp_mask", 32'(if0.resp_mask), 32'hC3C3);
        @(posedge clk); #1;

        // 4b: port-B address match does not stall a single-port op
        snoop_wen = 16'hFFFF; snoop_waddr = 5'd6;
        run_req("t4b", 3'd3, 5'd4, 5'd6, 2'b00, 16'hFFFF, 16'hC3C3, 1'b1, 1'b0);
        // 4c: write only to disabled lanes does not stall
        snoop_wen = 16'h00FF; snoop_waddr = 5'd4;
        run_req("t4c", 3'd3, 5'd4, 5'd6, 2'b00, 16'hFF00, 16'hC300, 1'b1, 1'b0);
        snoop_wen = 16'h0000;
        // 4d: port-B hazard does stall a two-port op (one cycle, no data change)
        if0.req_warp = 3'd3; if0.req_paddr_a = 5'd4; if0.req_paddr_b = 5'd6;
        if0.req_op = 2'b10; if0.req_lane_en = 16'hFFFF; if0.req_valid = 1'b1;
        @(posedge clk); #1;
        if0.req_valid = 1'b0;
        snoop_wen = 16'h0001; snoop_waddr = 5'd6;
        @(posedge clk); #1;
        model_write(16'h0000);
        snoop_wen = 16'h0000;
        chk("t4d.stall_rvld", 32'(if0.resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("t4d.resp_valid", 32'(if0.resp_valid), 32'd1);
        chk("t4d.resp_mask", 32'(if0.resp_mask), 32'hC3C3);
        @(posedge clk); #1;

        // 5: response backpressure
        if0.resp_ready = 1'b0;
        if0.req_warp = 3'd5; if0.req_paddr_a = 5'd1; if0.req_op = 2'b00;
        if0.req_lane_en = 16'hFFFF; if0.req_valid = 1'b1;
        @(posedge clk); #1;
        if0.req_valid = 1'b0;
        @(posedge clk); #1;
        mem[5][1] = 16'hFFFF;
        if0.req_warp = 3'd7; if0.req_paddr_a = 5'd2; if0.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5.hold%0d_rvld", i), 32'(if0.resp_valid), 32'd1);
            chk($sformatf("t5.hold%0d_mask", i), 32'(if0.resp_mask), 32'h00FF);
            chk($sformatf("t5.hold%0d_rdy", i), 32'(if0.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("t5.warp_kept", 32'(ws0), 32'd5);
        if0.resp_ready = 1'b1;
        @(posedge clk); #1;
        if0.req_valid = 1'b0;
        chk("t5.idle_busy", 32'(busy0), 32'd0);
        chk("t5.idle_rvld", 32'(if0.resp_valid), 32'd0);
        chk("t5.idle_rdy", 32'(if0.req_ready), 32'd1);
        @(posedge clk); #1;
        chk("t5.not_taken", 32'(busy0), 32'd0);

        // 6a: RD_LATENCY=2 timing
        mem[1][9] = 16'hBEEF;
        if2.req_warp = 3'd1; if2.req_paddr_a = 5'd9; if2.req_op = 2'b00;
        if2.req_lane_en = 16'hFFFF; if2.req_valid = 1'b1;
        @(posedge clk); #1;
        if2.req_valid = 1'b0;
        chk("t6a.issue_ren0", 32'(ren20), 32'hFFFF);
        @(posedge clk); #1;
        chk("t6a.wait1_rvld", 32'(if2.resp_valid), 32'd0);
        chk("t6a.wait1_ren0", 32'(ren20), 32'hFFFF);
        @(posedge clk); #1;
        chk("t6a.wait2_rvld", 32'(if2.resp_valid), 32'd0);
        chk("t6a.wait2_ren0", 32'(ren20), 32'hFFFF);
        @(posedge clk); #1;
        chk("t6a.resp_valid", 32'(if2.resp_valid), 32'd1);
        chk("t6a.resp_mask", 32'(if2.resp_mask), 32'hBEEF);
        chk("t6a.resp_ren0", 32'(ren20), 32'd0);
        @(posedge clk); #1;

        // 6b: reset in WAIT aborts without a response
        if2.req_warp = 3'd6; if2.req_paddr_a = 5'd17; if2.req_paddr_b = 5'd3;
        if2.req_op = 2'b01; if2.req_lane_en = 16'hFFFF; if2.req_valid = 1'b1;
        @(posedge clk); #1;
        if2.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6b.in_wait", 32'(busy2), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6b.busy", 32'(busy2), 32'd0);
        chk("t6b.req_ready", 32'(if2.req_ready), 32'd1);
        chk("t6b.ren", 32'({ren20, ren21}), 32'd0);
        chk("t6b.addr", 32'({ws2, ra20, ra21}), 32'd0);
        chk("t6b.resp", 32'({if2.resp_valid, if2.resp_mask, if2.resp_any, if2.resp_all}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("t6b.no_resp%0d", i), 32'(if2.resp_valid), 32'd0);
        end

        // 6c: sweep all warps and registers
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 32; r++)
                mem[w][r] = 16'((w * 32 + r) * 16'h0101) ^ 16'h5A3C;
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 32; r++) begin
                logic [15:0] ev;
                ev = 16'((w * 32 + r) * 16'h0101) ^ 16'h5A3C;
                run_req($sformatf("sweep_w%0d_r%0d", w, r), 3'(w), 5'(r), 5'd0, 2'b00,
                        16'hFFFF, ev, |ev, ev == 16'hFFFF);
            end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/predicate_mask_reader.md
Name: predicate_mask_reader

Overview:
- Read-side controller for predicate_register_block. It accepts a warp/predicate-register request over a valid/ready handshake and drives the block's warp_selector, read_en_0/1 and raddr_0/1.
- Captures the 16 per-lane predicate bits from one or both read ports, combines them (pass/AND/OR/ANDN) under a lane-enable mask, and returns the warp mask plus any/all flags to the issue stage.
- Stalls on a same-cycle write to a register being read, so results are never stale.

Parameters:
NUM_LANES, 16, lanes per warp; width of masks and read enables
WARP_W, 3, warp index width (8 warps)
PADDR_W, 5, predicate register address width (32 registers)
RD_LATENCY, 0, cycles from raddr/read_en to valid rdata in the register block (0 = combinational)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_warp  in  WARP_W  warp to read
req_paddr_a  in  PADDR_W  predicate register A (port 0)
req_paddr_b  in  PADDR_W  predicate register B (port 1)
req_op  in  2  00=A, 01=A&B, 10=A|B, 11=A&~B
req_lane_en  in  NUM_LANES  active lanes
warp_selector  out  WARP_W  to register block
read_en_0  out  NUM_LANES  port 0 per-lane read enable
read_en_1  out  NUM_LANES  port 1 per-lane read enable
raddr_0  out  PADDR_W  port 0 address
raddr_1  out  PADDR_W  port 1 address
rdata_0  in  NUM_LANES  port 0 data, bit i = rdata_0_i
rdata_1  in  NUM_LANES  port 1 data, bit i = rdata_1_i
snoop_wen  in  NUM_LANES  register block write_en this cycle
snoop_waddr  in  PADDR_W  register block waddr this cycle
resp_valid  out  1  response valid
resp_ready  in  1  response consumed
resp_mask  out  NUM_LANES  combined predicate, 0 in disabled lanes
resp_any  out  1  |resp_mask
resp_all  out  1  resp_mask == captured lane_en (1 if lane_en==0)
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE. req_ready=1 after reset deassert. All other outputs 0: read enables, raddr, warp_selector, resp_*, busy. rst in any state aborts the in-flight request; it produces no response.
- IDLE: req_ready=1. On req_valid, latch warp, paddr_a/b, op and lane_en, then go to ISSUE.
- ISSUE:
  - Drive warp_selector=warp, raddr_0=paddr_a, read_en_0=lane_en.
  - For op!=00, drive raddr_1=paddr_b and read_en_1=lane_en; for op==00, read_en_1=0.
  - Hazard: if |(snoop_wen & lane_en) and snoop_waddr equals paddr_a, or equals paddr_b with op!=00, stay in ISSUE and re-evaluate the next cycle.
  - Otherwise, with RD_LATENCY==0, capture rdata at the end of this cycle and go to RESP. With RD_LATENCY>0, go to WAIT.
- WAIT: hold the ISSUE outputs for RD_LATENCY cycles using a down-counter. Capture at the end of the last WAIT cycle, then go to RESP.
- Combine at capture:
  - mask = f(op, rdata_0, rdata_1) & lane_en.
  - Register mask, any and all.
- RESP:
  - read_en_0/1 = 0; raddr and warp_selector hold their last values.
  - resp_valid=1 with stable payload until resp_ready; on resp_valid&resp_ready go to IDLE.
  - req_ready=0 outside IDLE: no new request is accepted in the handshake cycle.
- Latency with no hazard and immediate resp_ready: accept at T, ISSUE at T+1, WAIT T+2..T+1+RD_LATENCY, resp_valid at T+2+RD_LATENCY. Throughput is one request per 3+RD_LATENCY cycles.
- Lanes with lane_en=0 are never read and always report 0.
- paddr_a==paddr_b is legal; both ports read the same register.
- The warp index is not checked against the snoop: the register block writes only the selected warp, and warp_selector is owned by this block while busy.

Test Plan:
1. Reset, then warp 0 has P3 all lanes =1. Request warp=0, a=3, op=00, lane_en=FFFF, RD_LATENCY=0 -> resp_valid 2 cycles after accept; read_en_0=FFFF and read_en_1=0000 during ISSUE; resp_mask=FFFF, any=1, all=1.
2. Warp 5: P1=00FF, P2=0F0F, lane_en=FFFF. Ops 01/10/11 -> resp_mask 000F / 0FFF / 00F0 respectively; both read enables =FFFF during ISSUE.
3. P1=FFFF, lane_en=8001, op=00 -> read_en_0=8001, resp_mask=8001, all=1. Repeat with lane_en=0000 -> resp_mask=0000, any=0, all=1.
4. Hazard: snoop_wen=FFFF and snoop_waddr=a held 2 cycles after accept -> stays in ISSUE 2 extra cycles. resp_valid at T+4 and reflects the newly written data.
5. Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_mask held constant, req_ready=0, a new req_valid is not accepted. Raise resp_ready -> IDLE next cycle.
6. Assert rst during WAIT (RD_LATENCY=2) -> next cycle all outputs 0, busy=0, req_ready=1, no resp_valid for the aborted request. Then sweep all 8 warps × 32 registers with op=00 and lane_en=FFFF -> each mask matches the written data.
